// File: rtl/dac_driver_pkg.sv
// Shared types and helpers for the segmented DAC driver: power sequencer
// states, MSB field width derivation and the cyclic unit-cell selector.
package dac_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON,
        ST_DRAIN
    } state_t;

    function automatic int msb_w(input int ntherm);
        return $clog2(ntherm + 1);
    endfunction

    // One bit of the rotated thermometer mask: cell idx is on when it lies within
    // count cells of ptr, walking upward and wrapping at ncells.
    function automatic logic rotate_mask_bit(input int idx, input int ptr,
                                             input int count, input int ncells);
        int offs;
        offs = idx - ptr;
        if (offs < 0) begin
            offs = offs + ncells;
        end
        return (offs < count);
    endfunction

endpackage

// File: rtl/dac_dwa_decoder.sv
// Thermometer mask generator for the unit cells, with the data-weighted-averaging
// pointer that advances by the number of cells used on every loaded code.
module dac_dwa_decoder
    import dac_driver_pkg::*;
#(
    parameter  int NTHERM = 17,
    localparam int MSB_W  = msb_w(NTHERM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_dem_en,
    input  logic [MSB_W-1:0]  i_count,
    output logic [NTHERM-1:0] o_mask
);

    logic [MSB_W-1:0] r_ptr;
    logic [MSB_W-1:0] w_start;
    logic [MSB_W:0]   w_sum;
    logic [MSB_W-1:0] w_ptr_next;

    // count never exceeds NTHERM and the pointer stays below it, so one
    // conditional subtract is enough for the modulo
    always_comb begin
        w_start = i_dem_en ? r_ptr : '0;
        w_sum   = {1'b0, w_start} + {1'b0, i_count};
        if (w_sum >= (MSB_W + 1)'(NTHERM)) begin
            w_ptr_next = MSB_W'(w_sum - (MSB_W + 1)'(NTHERM));
        end else begin
            w_ptr_next = w_sum[MSB_W-1:0];
        end
        o_mask = '0;
        for (int i = 0; i < NTHERM; i++) begin
            o_mask[i] = rotate_mask_bit(i, int'(w_start), int'(i_count), NTHERM);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_dem_en ? w_ptr_next : '0;
        end
    end

endmodule

// File: rtl/dac_segment_driver.sv
// Segmented DAC cell driver: clamps and splits each code into binary LSB and
// thermometer MSB cells, drives complementary pairs, and sequences power up/down.
module dac_segment_driver
    import dac_driver_pkg::*;
#(
    parameter  int BIN_W     = 7,
    parameter  int NTHERM    = 17,
    parameter  int WAKE_CYC  = 4,
    parameter  int DRAIN_CYC = 2,
    localparam int MSB_W     = msb_w(NTHERM),
    localparam int CODE_W    = BIN_W + MSB_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pdb,
    input  logic              i_dem_en,
    input  logic              i_in_valid,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_ready,
    output logic              o_drv_en,
    output logic [BIN_W-1:0]  o_bin_out,
    output logic [BIN_W-1:0]  o_bin_outb,
    output logic [NTHERM-1:0] o_therm_out,
    output logic [NTHERM-1:0] o_therm_outb,
    output logic              o_sat
);

    localparam int CNT_MAX = (WAKE_CYC > DRAIN_CYC) ? WAKE_CYC : DRAIN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_s1_new;
    logic             r_s1_dem;
    logic             r_s1_sat;
    logic [MSB_W-1:0] r_s1_msb;
    logic [BIN_W-1:0] r_s1_lsb;

    logic [BIN_W-1:0]  r_bin;
    logic [BIN_W-1:0]  r_binb;
    logic [NTHERM-1:0] r_therm;
    logic [NTHERM-1:0] r_thermb;
    logic              r_sat;

    logic              w_accept;
    logic              w_load;
    logic              w_over;
    logic [MSB_W-1:0]  w_msb_raw;
    logic [MSB_W-1:0]  w_msb_cl;
    logic [BIN_W-1:0]  w_lsb_cl;
    logic [NTHERM-1:0] w_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter is loaded with N-1 on entry and the state advances on the
    // cycle it is seen at zero, so WAKE and DRAIN each last exactly N cycles.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (i_pdb) begin
                    w_state_next = ST_WAKE;
                    w_cnt_next   = CNT_W'(WAKE_CYC - 1);
                end
            end
            ST_WAKE: begin
                if (!i_pdb) begin
                    w_state_next = ST_OFF;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_ON;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (!i_pdb) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = CNT_W'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_OFF;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_OFF;
            end
        endcase
    end

    assign o_ready  = (r_state == ST_ON);
    assign o_drv_en = (r_state != ST_OFF);

    assign w_accept  = o_ready & i_in_valid;
    assign w_load    = r_s1_new && (r_state == ST_ON) && (w_state_next == ST_ON);
    assign w_msb_raw = i_code[CODE_W-1:BIN_W];
    assign w_over    = (w_msb_raw > MSB_W'(NTHERM));
    assign w_msb_cl  = w_over ? MSB_W'(NTHERM) : w_msb_raw;
    assign w_lsb_cl  = w_over ? '1 : i_code[BIN_W-1:0];

    // Leaving ON clears the held code, so codes in flight are dropped and the
    // next ON entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || (w_state_next != ST_ON)) begin
            r_s1_new <= 1'b0;
            r_s1_dem <= 1'b0;
            r_s1_sat <= 1'b0;
            r_s1_msb <= '0;
            r_s1_lsb <= '0;
        end else if (w_accept) begin
            r_s1_new <= 1'b1;
            r_s1_dem <= i_dem_en;
            r_s1_sat <= w_over;
            r_s1_msb <= w_msb_cl;
            r_s1_lsb <= w_lsb_cl;
        end else begin
            r_s1_new <= 1'b0;
        end
    end

    dac_dwa_decoder #(
        .NTHERM (NTHERM)
    ) u_dwa (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_dem_en (r_s1_dem),
        .i_count  (r_s1_msb),
        .o_mask   (w_mask)
    );

    // Drive registers follow the next state so the cell drive changes on the
    // same edge as the sequencer state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin    <= '0;
            r_binb   <= '0;
            r_therm  <= '0;
            r_thermb <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (w_state_next)
                ST_ON: begin
                    if (w_load) begin
                        r_bin    <= r_s1_lsb;
                        r_binb   <= ~r_s1_lsb;
                        r_therm  <= w_mask;
                        r_thermb <= ~w_mask;
                        r_sat    <= r_s1_sat;
                    end
                end
                ST_WAKE, ST_DRAIN: begin
                    r_bin    <= '0;
                    r_binb   <= '1;
                    r_therm  <= '0;
                    r_thermb <= '1;
                    r_sat    <= 1'b0;
                end
                default: begin
                    r_bin    <= '0;
                    r_binb   <= '0;
                    r_therm  <= '0;
                    r_thermb <= '0;
                    r_sat    <= 1'b0;
                end
            endcase
        end
    end

    assign o_bin_out    = r_bin;
    assign o_bin_outb   = r_binb;
    assign o_therm_out  = r_therm;
    assign o_therm_outb = r_thermb;
    assign o_sat        = r_sat;

endmodule
